// File: rtl/tank_pkg.sv
// Shared encodings for the tank game: bullet directions, playfield cell
// categories and the bullet sweep state machine.
package tank_pkg;

    typedef enum logic [2:0] {
        DIR_LEFT  = 3'd0,
        DIR_RIGHT = 3'd1,
        DIR_UP    = 3'd2,
        DIR_DOWN  = 3'd3
    } dir_e;

    typedef enum logic [1:0] {
        CAT_NONE   = 2'd0,
        CAT_WALL   = 2'd1,
        CAT_TANK   = 2'd2,
        CAT_BULLET = 2'd3
    } cat_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_e;

endpackage

// File: rtl/slot_alloc.sv
// Lowest-index free slot finder over the bullet valid vector.
module slot_alloc #(
    parameter int N_SLOTS = 16,
    parameter int IW      = $clog2(N_SLOTS)
) (
    input  logic [N_SLOTS-1:0] valid,
    output logic [IW-1:0]      free_idx,
    output logic               any_free
);

    // Descending scan so the lowest free index is the last one written.
    always_comb begin
        free_idx = '0;
        any_free = 1'b0;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            free_idx = valid[i] ? free_idx : IW'(i);
            any_free = any_free | ~valid[i];
        end
    end

endmodule

// File: rtl/bullet_engine.sv
// Bullet slot table: fire arbitration and spawning, a one-slot-per-cycle
// movement sweep per tick, and a registered per-pixel bullet hit test.
module bullet_engine
    import tank_pkg::*;
#(
    parameter int N_SLOTS    = 16,
    parameter int N_SHOOTERS = 2,
    parameter int GRID_W     = 60,
    parameter int GRID_H     = 45,
    parameter int BLOCK_SIZE = 10,
    parameter int BORDER     = 10,
    parameter int CW         = 10
) (
    input  logic                     clk_100mhz,
    input  logic                     rst,
    input  logic [N_SHOOTERS-1:0]    fire,
    input  logic [N_SHOOTERS*CW-1:0] fire_x,
    input  logic [N_SHOOTERS*CW-1:0] fire_y,
    input  logic [N_SHOOTERS*3-1:0]  fire_dir,
    output logic [N_SHOOTERS-1:0]    fire_ack,
    input  logic                     tick,
    input  logic [CW-1:0]            pixel_x,
    input  logic [CW-1:0]            pixel_y,
    output logic                     pixel_bullet,
    output logic [7:0]               n_active,
    output logic                     busy,
    output logic                     tick_overrun
);

    localparam int IW = $clog2(N_SLOTS);
    localparam int SW = (N_SHOOTERS > 1) ? $clog2(N_SHOOTERS) : 1;
    localparam int PW = CW + 8;
    localparam logic [CW:0]    ONE_L    = (CW+1)'(1);
    localparam logic [CW:0]    GW_L     = (CW+1)'(GRID_W);
    localparam logic [CW:0]    GH_L     = (CW+1)'(GRID_H);
    localparam logic [IW-1:0]  LAST_PTR = IW'(N_SLOTS - 1);
    localparam logic [PW-1:0]  BS_L     = PW'(BLOCK_SIZE);
    localparam logic [PW-1:0]  BD_L     = PW'(BORDER);

    // Returns {in_grid, x, y}; the extra bit makes a step left/up from 0 wrap far out of range.
    function automatic logic [2*CW:0] step_cell(input logic [CW-1:0] cx,
                                                input logic [CW-1:0] cy,
                                                input logic [2:0]    d);
        logic [CW:0] wx;
        logic [CW:0] wy;
        wx = {1'b0, cx};
        wy = {1'b0, cy};
        case (d)
            DIR_LEFT:  wx = wx - ONE_L;
            DIR_RIGHT: wx = wx + ONE_L;
            DIR_UP:    wy = wy - ONE_L;
            DIR_DOWN:  wy = wy + ONE_L;
            default:   wx = {1'b0, cx};
        endcase
        return {(wx < GW_L) && (wy < GH_L), wx[CW-1:0], wy[CW-1:0]};
    endfunction

    logic [N_SLOTS-1:0] valid_r;
    logic [N_SLOTS-1:0] valid_nx_s;
    logic [CW-1:0]      x_r   [N_SLOTS];
    logic [CW-1:0]      y_r   [N_SLOTS];
    logic [2:0]         dir_r [N_SLOTS];
    state_e             state_r;
    state_e             state_nx_s;
    logic [IW-1:0]      ptr_r;
    logic [IW-1:0]      ptr_nx_s;
    logic               overrun_nx_s;
    logic               tick_overrun_r;
    logic               busy_r;
    logic               pixel_bullet_r;
    logic [7:0]         n_active_r;
    logic [7:0]         cnt_s;
    logic [IW-1:0]      free_idx_s;
    logic               any_free_s;
    logic [SW-1:0]      sel_s;
    logic               sel_valid_s;
    logic               accept_s;
    logic               alloc_en_s;
    logic [CW-1:0]      sel_x_s;
    logic [CW-1:0]      sel_y_s;
    logic [2:0]         sel_dir_s;
    logic [2*CW:0]      spawn_s;
    logic [2*CW:0]      swept_s;
    logic               sweep_move_s;
    logic               hit_s;

    slot_alloc #(.N_SLOTS(N_SLOTS), .IW(IW)) u_slot_alloc (
        .valid    (valid_r),
        .free_idx (free_idx_s),
        .any_free (any_free_s)
    );

    // Fixed-priority fire arbitration and spawn cell computation.
    always_comb begin
        sel_s       = '0;
        sel_valid_s = 1'b0;
        for (int i = N_SHOOTERS - 1; i >= 0; i--) begin
            sel_s       = fire[i] ? SW'(i) : sel_s;
            sel_valid_s = sel_valid_s | fire[i];
        end
        sel_x_s    = fire_x[int'(sel_s)*CW +: CW];
        sel_y_s    = fire_y[int'(sel_s)*CW +: CW];
        sel_dir_s  = fire_dir[int'(sel_s)*3 +: 3];
        spawn_s    = step_cell(sel_x_s, sel_y_s, sel_dir_s);
        accept_s   = sel_valid_s & any_free_s & ~rst;
        alloc_en_s = accept_s & spawn_s[2*CW];
        for (int i = 0; i < N_SHOOTERS; i++) begin
            fire_ack[i] = accept_s & (sel_s == SW'(i));
        end
    end

    // Sweep step for the slot under ptr and the resulting valid vector and count.
    always_comb begin
        sweep_move_s = (state_r == ST_SWEEP) & valid_r[ptr_r];
        swept_s      = step_cell(x_r[ptr_r], y_r[ptr_r], dir_r[ptr_r]);
        valid_nx_s   = valid_r;
        if (sweep_move_s && !swept_s[2*CW]) begin
            valid_nx_s[ptr_r] = 1'b0;
        end else begin
            valid_nx_s[ptr_r] = valid_r[ptr_r];
        end
        if (alloc_en_s) begin
            valid_nx_s[free_idx_s] = 1'b1;
        end else begin
            valid_nx_s[free_idx_s] = valid_nx_s[free_idx_s];
        end
        cnt_s = 8'd0;
        for (int i = 0; i < N_SLOTS; i++) begin
            cnt_s = cnt_s + {7'd0, valid_nx_s[i]};
        end
    end

    // Sweep FSM next-state logic.
    always_comb begin
        state_nx_s   = state_r;
        ptr_nx_s     = ptr_r;
        overrun_nx_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (tick) begin
                    state_nx_s = ST_SWEEP;
                    ptr_nx_s   = '0;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SWEEP: begin
                overrun_nx_s = tick;
                if (ptr_r == LAST_PTR) begin
                    state_nx_s = ST_IDLE;
                    ptr_nx_s   = '0;
                end else begin
                    ptr_nx_s   = ptr_r + {{(IW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                ptr_nx_s   = '0;
            end
        endcase
    end

    // Pixel-in-bullet test against every valid slot.
    always_comb begin
        hit_s = 1'b0;
        for (int i = 0; i < N_SLOTS; i++) begin
            hit_s = hit_s | (valid_r[i]
                & (PW'(pixel_x) >= PW'(x_r[i]) * BS_L + BD_L)
                & (PW'(pixel_x) <  PW'(x_r[i]) * BS_L + BD_L + BS_L)
                & (PW'(pixel_y) >= PW'(y_r[i]) * BS_L + BD_L)
                & (PW'(pixel_y) <  PW'(y_r[i]) * BS_L + BD_L + BS_L));
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            valid_r        <= '0;
            state_r        <= ST_IDLE;
            ptr_r          <= '0;
            busy_r         <= 1'b0;
            tick_overrun_r <= 1'b0;
            n_active_r     <= 8'd0;
            pixel_bullet_r <= 1'b0;
        end else begin
            valid_r        <= valid_nx_s;
            state_r        <= state_nx_s;
            ptr_r          <= ptr_nx_s;
            busy_r         <= (state_nx_s == ST_SWEEP);
            tick_overrun_r <= overrun_nx_s;
            n_active_r     <= cnt_s;
            pixel_bullet_r <= hit_s;
        end
    end

    // Slot payload; the allocator only targets invalid slots and the sweep only valid ones.
    always_ff @(posedge clk_100mhz) begin
        if (sweep_move_s && swept_s[2*CW]) begin
            x_r[ptr_r] <= swept_s[2*CW-1:CW];
            y_r[ptr_r] <= swept_s[CW-1:0];
        end
        if (alloc_en_s) begin
            x_r[free_idx_s]   <= spawn_s[2*CW-1:CW];
            y_r[free_idx_s]   <= spawn_s[CW-1:0];
            dir_r[free_idx_s] <= sel_dir_s;
        end
    end

    assign pixel_bullet = pixel_bullet_r;
    assign n_active     = n_active_r;
    assign busy         = busy_r;
    assign tick_overrun = tick_overrun_r;

endmodule

// File: tb/tb_bullet_engine.sv
// Directed bench for bullet_engine: firing, arbitration, sweep timing,
// off-grid deletion, full-table back-pressure, overrun and the pixel test.
module tb_bullet_engine;

    localparam int CW = 10;

    logic        clk_100mhz = 1'b0;
    logic        rst;
    logic        tick;
    logic [1:0]  fire;
    logic [19:0] fire_x;
    logic [19:0] fire_y;
    logic [5:0]  fire_dir;
    logic [1:0]  fire_ack;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        pixel_bullet;
    logic [7:0]  n_active;
    logic        busy;
    logic        tick_overrun;

    int total = 0;
    int bad   = 0;
    int cnt;

    bullet_engine #(
        .N_SLOTS(16), .N_SHOOTERS(2), .GRID_W(60), .GRID_H(45),
        .BLOCK_SIZE(10), .BORDER(10), .CW(CW)
    ) dut (
        .clk_100mhz   (clk_100mhz),
        .rst          (rst),
        .fire         (fire),
        .fire_x       (fire_x),
        .fire_y       (fire_y),
        .fire_dir     (fire_dir),
        .fire_ack     (fire_ack),
        .tick         (tick),
        .pixel_x      (pixel_x),
        .pixel_y      (pixel_y),
        .pixel_bullet (pixel_bullet),
        .n_active     (n_active),
        .busy         (busy),
        .tick_overrun (tick_overrun)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic step();
        @(posedge clk_100mhz);
        @(negedge clk_100mhz);
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        fire = 2'b00;
        tick = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic shoot(input int ch, input int x, input int y, input int d,
                         input logic [1:0] exp_ack, input string tag);
        fire_x[ch*CW +: CW]  = CW'(x);
        fire_y[ch*CW +: CW]  = CW'(y);
        fire_dir[ch*3 +: 3]  = 3'(d);
        fire[ch]             = 1'b1;
        #1;
        check(tag, 32'(fire_ack), 32'(exp_ack));
        step();
        fire[ch] = 1'b0;
        #1;
    endtask

    task automatic probe(input int px, input int py, input logic exp, input string tag);
        pixel_x = CW'(px);
        pixel_y = CW'(py);
        step();
        #1;
        check(tag, 32'(pixel_bullet), 32'(exp));
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 40) begin
            n++;
            step();
            #1;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; tick = 1'b0; fire = 2'b00;
        fire_x = '0; fire_y = '0; fire_dir = '0;
        pixel_x = '0; pixel_y = '0;
        step();
        step();
        #1;
        check("rst_n_active", 32'(n_active), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(tick_overrun), 32'd0);
        check("rst_pixel", 32'(pixel_bullet), 32'd0);
        fire = 2'b01;
        #1;
        check("rst_no_ack", 32'(fire_ack), 32'd0);
        fire = 2'b00;
        rst  = 1'b0;
        #1;

        // single shot to the right from (5,5)
        shoot(0, 5, 5, 1, 2'b01, "fire_first");
        check("n_after_first", 32'(n_active), 32'd1);
        probe(70, 60, 1'b1, "slot0_at_6_5");
        probe(60, 60, 1'b0, "shooter_cell_empty");

        // both channels at once: ch0 up from (10,10), ch1 down from (20,20)
        do_reset();
        fire_x = {10'd20, 10'd10};
        fire_y = {10'd20, 10'd10};
        fire_dir = {3'd3, 3'd2};
        fire = 2'b11;
        #1;
        check("dual_ack_ch0", 32'(fire_ack), 32'd1);
        step();
        fire = 2'b10;
        #1;
        check("dual_ack_ch1", 32'(fire_ack), 32'd2);
        step();
        fire = 2'b00;
        #1;
        check("dual_n_active", 32'(n_active), 32'd2);
        probe(219, 229, 1'b1, "ch1_cell_far_edge");
        probe(220, 229, 1'b0, "ch1_cell_past_edge");
        probe(110, 100, 1'b1, "ch0_cell_up");

        // pixel boundaries and latency around cell (3,4)
        do_reset();
        shoot(0, 2, 4, 1, 2'b01, "fire_3_4");
        probe(39, 50, 1'b0, "pix_left_out");
        pixel_x = 10'd40;
        pixel_y = 10'd50;
        #1;
        check("pix_latency", 32'(pixel_bullet), 32'd0);
        step();
        #1;
        check("pix_inside", 32'(pixel_bullet), 32'd1);
        probe(40, 49, 1'b0, "pix_above_out");

        // right-edge bullet deleted on the first sweep cycle
        do_reset();
        shoot(0, 58, 10, 1, 2'b01, "fire_edge");
        check("n_edge", 32'(n_active), 32'd1);
        tick = 1'b1;
        step();
        tick = 1'b0;
        #1;
        check("busy_start", 32'(busy), 32'd1);
        check("n_before_delete", 32'(n_active), 32'd1);
        cnt = 1;
        step();
        #1;
        check("n_after_delete", 32'(n_active), 32'd0);
        while (busy && cnt < 40) begin
            cnt++;
            step();
            #1;
        end
        check("sweep_len", 32'(cnt), 32'd16);
        check("no_overrun", 32'(tick_overrun), 32'd0);

        // non-moving direction code and off-grid spawns
        shoot(0, 7, 7, 5, 2'b01, "fire_dir5");
        shoot(0, 0, 5, 0, 2'b01, "ack_underflow_left");
        shoot(1, 10, 44, 3, 2'b10, "ack_bottom_out");
        check("no_alloc_off_grid", 32'(n_active), 32'd1);
        tick = 1'b1;
        step();
        tick = 1'b0;
        #1;
        wait_idle("dir5_sweep_done");
        probe(80, 80, 1'b1, "dir5_stays");

        // full table back-pressure
        do_reset();
        shoot(0, 58, 0, 1, 2'b01, "fill_slot0");
        for (int k = 1; k < 16; k++) begin
            shoot(0, 10, k, 4, 2'b01, "fill_slot");
        end
        check("n_full", 32'(n_active), 32'd16);
        fire_x[19:10] = 10'd30;
        fire_y[19:10] = 10'd30;
        fire_dir[5:3] = 3'd1;
        fire = 2'b10;
        #1;
        check("full_no_ack", 32'(fire_ack), 32'd0);
        step();
        #1;
        check("full_still_wait", 32'(fire_ack), 32'd0);
        tick = 1'b1;
        step();
        tick = 1'b0;
        #1;
        check("full_sweep_busy", 32'(busy), 32'd1);
        check("full_sweep0_no_ack", 32'(fire_ack), 32'd0);
        step();
        #1;
        check("ack_after_delete", 32'(fire_ack), 32'd2);
        check("n_after_delete15", 32'(n_active), 32'd15);
        step();
        fire = 2'b00;
        #1;
        check("n_refill", 32'(n_active), 32'd16);
        wait_idle("full_sweep_done");
        probe(320, 310, 1'b1, "low_slot_not_moved");
        probe(330, 310, 1'b0, "low_slot_not_ahead");

        // tick during sweep plus allocation above ptr
        do_reset();
        shoot(0, 5, 5, 1, 2'b01, "ovr_fire0");
        tick = 1'b1;
        step();
        tick = 1'b0;
        #1;
        cnt = 0;
        for (int k = 1; k <= 30; k++) begin
            if (busy) cnt++;
            if (k == 1) begin
                fire_x[9:0]  = 10'd20;
                fire_y[9:0]  = 10'd20;
                fire_dir[2:0] = 3'd3;
                fire = 2'b01;
                #1;
                check("fire_in_sweep", 32'(fire_ack), 32'd1);
            end
            if (k == 2) fire = 2'b00;
            if (k == 5) tick = 1'b1;
            if (k == 6) begin
                tick = 1'b0;
                check("overrun_pulse", 32'(tick_overrun), 32'd1);
            end
            if (k == 7) check("overrun_single", 32'(tick_overrun), 32'd0);
            step();
            #1;
        end
        check("one_sweep_only", 32'(cnt), 32'd16);
        check("ovr_n_active", 32'(n_active), 32'd2);
        probe(80, 60, 1'b1, "moved_right");
        probe(70, 60, 1'b0, "old_cell_clear");
        probe(210, 230, 1'b1, "high_slot_moved");

        // reset in the middle of a sweep
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();
        step();
        #1;
        check("busy_before_rst", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("rst_abort_busy", 32'(busy), 32'd0);
        check("rst_abort_n", 32'(n_active), 32'd0);
        step();
        #1;
        check("rst_stays_idle", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
